// File: rtl/vend_buyer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vend_buyer_if
//  Description : Signal bundle between the vending buyer and the vending
//                machine / purchase requester.
//                slave  : the buyer side (vend_buyer) - drives coins, vend,
//                         status and result flags.
//                master : the requester / machine side - drives start,
//                         target, serve and change.
//  Parameters  : WIDTH - width of target and paid amounts (nickel units).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vend_buyer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] target;
    logic             serve;
    logic             change;
    logic             nickel;
    logic             dime;
    logic             quarter;
    logic             dispense;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] paid;
    logic             served;
    logic             changed;
    logic             timeout;

    modport slave (
        input  start, target, serve, change,
        output nickel, dime, quarter, dispense, done, busy, paid,
               served, changed, timeout
    );

    modport master (
        output start, target, serve, change,
        input  nickel, dime, quarter, dispense, done, busy, paid,
               served, changed, timeout
    );
endinterface
`default_nettype wire

// File: rtl/vend_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_buyer
//  Description : Automated buyer for a coin vending machine. On a purchase
//                request it inserts coins greedily (quarter/dime/nickel,
//                worth 5/2/1 units) with one idle cycle between coins until
//                the latched target is reached, requests a vend, then waits
//                for the machine's serve/change indication and acknowledges
//                it with done.
//  Ports       : clk - clock (rising edge)
//                rst - asynchronous active-low reset
//                vb  - vend_buyer_if.slave bundle:
//                      in : start, target, serve, change
//                      out: nickel, dime, quarter, dispense, done, busy,
//                           paid, served, changed, timeout
//  Options     : VEND_BUYER_TIMEOUT_EN - when defined, gives up waiting for
//                the machine after 16 cycles in WAIT and sets timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_buyer #(
    parameter int WIDTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vend_buyer_if.slave     vb
);

    localparam logic [WIDTH-1:0] c_NICKEL  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_DIME    = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_QUARTER = WIDTH'(5);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_COIN = 3'd1,
        S_GAP  = 3'd2,
        S_VEND = 3'd3,
        S_WAIT = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_paid;
    logic             r_nickel;
    logic             r_dime;
    logic             r_quarter;
    logic             r_dispense;
    logic             r_done;
    logic             r_busy;
    logic             r_served;
    logic             r_changed;

`ifdef VEND_BUYER_TIMEOUT_EN
    logic [4:0]       r_wait_cnt;
    logic             r_timeout;
`endif

    // Greedy coin choice for the next insertion. In IDLE the coin goes out on
    // the same edge that accepts start, so the remaining amount is taken from
    // the live target input rather than the not-yet-loaded latch.
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_coin_val;
    logic             w_pick_q;
    logic             w_pick_d;
    logic             w_pick_n;

    always_comb begin
        w_rem      = (r_state == S_IDLE) ? vb.target : (r_target - r_paid);
        w_pick_q   = 1'b0;
        w_pick_d   = 1'b0;
        w_pick_n   = 1'b0;
        w_coin_val = c_NICKEL;
        if (w_rem >= c_QUARTER) begin
            w_pick_q   = 1'b1;
            w_coin_val = c_QUARTER;
        end else if (w_rem >= c_DIME) begin
            w_pick_d   = 1'b1;
            w_coin_val = c_DIME;
        end else begin
            w_pick_n   = 1'b1;
            w_coin_val = c_NICKEL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_paid     <= '0;
            r_nickel   <= 1'b0;
            r_dime     <= 1'b0;
            r_quarter  <= 1'b0;
            r_dispense <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_served   <= 1'b0;
            r_changed  <= 1'b0;
`ifdef VEND_BUYER_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            // Coin and vend lines are single-cycle pulses by default.
            r_nickel   <= 1'b0;
            r_dime     <= 1'b0;
            r_quarter  <= 1'b0;
            r_dispense <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (vb.start) begin
                        r_target  <= vb.target;
                        r_served  <= 1'b0;
                        r_changed <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef VEND_BUYER_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        if (vb.target == '0) begin
                            r_paid     <= '0;
                            r_dispense <= 1'b1;
                            r_state    <= S_VEND;
                        end else begin
                            r_paid    <= w_coin_val;
                            r_quarter <= w_pick_q;
                            r_dime    <= w_pick_d;
                            r_nickel  <= w_pick_n;
                            r_state   <= S_COIN;
                        end
                    end
                end

                S_COIN: begin
                    r_state <= S_GAP;
                end

                S_GAP: begin
                    if (r_paid < r_target) begin
                        r_paid    <= r_paid + w_coin_val;
                        r_quarter <= w_pick_q;
                        r_dime    <= w_pick_d;
                        r_nickel  <= w_pick_n;
                        r_state   <= S_COIN;
                    end else begin
                        r_dispense <= 1'b1;
                        r_state    <= S_VEND;
                    end
                end

                S_VEND: begin
`ifdef VEND_BUYER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (vb.serve || vb.change) begin
                        r_served  <= vb.serve;
                        r_changed <= vb.change;
                        r_done    <= 1'b1;
                        r_state   <= S_ACK;
                    end
`ifdef VEND_BUYER_TIMEOUT_EN
                    else if (r_wait_cnt == 5'd15) begin
                        // Sixteenth silent cycle: abandon without done.
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 5'd1;
                    end
`endif
                end

                S_ACK: begin
                    if (vb.serve || vb.change) begin
                        // Late indications during the acknowledge are sticky.
                        r_served  <= r_served  | vb.serve;
                        r_changed <= r_changed | vb.change;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vb.nickel   = r_nickel;
    assign vb.dime     = r_dime;
    assign vb.quarter  = r_quarter;
    assign vb.dispense = r_dispense;
    assign vb.done     = r_done;
    assign vb.busy     = r_busy;
    assign vb.paid     = r_paid;
    assign vb.served   = r_served;
    assign vb.changed  = r_changed;
`ifdef VEND_BUYER_TIMEOUT_EN
    assign vb.timeout  = r_timeout;
`else
    assign vb.timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_buyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_buyer
//  Description : Self-checking bench for vend_buyer. Purchase vectors come
//                from a table; the expected per-cycle output words of each
//                purchase are queued when start is driven and popped and
//                compared cycle by cycle. Hand-written sequences cover the
//                serve/change acknowledge, reset mid-purchase and the WAIT
//                timeout (VEND_BUYER_TIMEOUT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_buyer;

    localparam int c_WIDTH = 4;

    logic clk;
    logic rst;

    vend_buyer_if #(.WIDTH(c_WIDTH)) vb ();

    vend_buyer #(.WIDTH(c_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .vb  (vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // {nickel,dime,quarter,dispense,done,busy,served,changed,timeout,paid}
    logic [12:0] w_obs;
    assign w_obs = {vb.nickel, vb.dime, vb.quarter, vb.dispense, vb.done,
                    vb.busy, vb.served, vb.changed, vb.timeout, vb.paid};

    logic [12:0] sb_q[$];

    typedef struct {
        logic [3:0] tgt;
        int         n;
        logic [7:0] codes;  // 2 bits per coin, first coin in [1:0]; 1=N 2=D 3=Q
        bit         noise;  // drive start/serve/change while busy
    } vec_t;

    vec_t vecs[9];

    function automatic logic [12:0] mk(input logic n, input logic d,
                                       input logic q, input logic disp,
                                       input logic dn, input logic bsy,
                                       input logic srv, input logic chg,
                                       input logic to, input logic [3:0] p);
        return {n, d, q, disp, dn, bsy, srv, chg, to, p};
    endfunction

    function automatic logic [3:0] coin_val(input logic [1:0] c);
        case (c)
            2'd1:    return 4'd1;
            2'd2:    return 4'd2;
            2'd3:    return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [12:0] act,
                         input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b (n d q disp done busy srv chg to paid[4])",
                     name, $time, act, exp);
        end
    endtask

    // Drive one purchase from start through the first WAIT cycle.
    task automatic run_purchase(input logic [3:0] tgt, input int n,
                                input logic [7:0] codes, input bit noise);
        logic [3:0]  p;
        logic [1:0]  c;
        logic [12:0] e;
        p = 4'd0;
        for (int k = 0; k < n; k++) begin
            c = codes[2*k +: 2];
            p = p + coin_val(c);
            sb_q.push_back(mk(c == 2'd1, c == 2'd2, c == 2'd3, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, p));
            sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, p));
        end
        sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                          1'b0, tgt));
        sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          1'b0, tgt));
        @(negedge clk);
        vb.start  = 1'b1;
        vb.target = tgt;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            if (noise && sb_q.size() > 2) begin
                vb.start  = 1'b1;
                vb.target = 4'd15;
                vb.serve  = 1'b1;
                vb.change = 1'b1;
            end else begin
                vb.start  = 1'b0;
                vb.target = tgt;
                vb.serve  = 1'b0;
                vb.change = 1'b0;
            end
            e = sb_q.pop_front();
            check("purchase", w_obs, e);
        end
    endtask

    // Machine response while the DUT sits in WAIT.
    task automatic respond(input int mode, input logic [3:0] tgt);
        case (mode)
            0: begin // serve for two cycles
                @(negedge clk); vb.serve = 1'b1; vb.change = 1'b0;
                @(negedge clk);
                check("serve2_ack1", w_obs, mk(0,0,0,0,1,1,1,0,0,tgt));
                @(negedge clk); vb.serve = 1'b0;
                check("serve2_ack2", w_obs, mk(0,0,0,0,1,1,1,0,0,tgt));
                @(negedge clk);
                check("serve2_idle", w_obs, mk(0,0,0,0,0,0,1,0,0,tgt));
            end
            1: begin // serve and change together
                @(negedge clk); vb.serve = 1'b1; vb.change = 1'b1;
                @(negedge clk); vb.serve = 1'b0; vb.change = 1'b0;
                check("both_ack", w_obs, mk(0,0,0,0,1,1,1,1,0,tgt));
                @(negedge clk);
                check("both_idle", w_obs, mk(0,0,0,0,0,0,1,1,0,tgt));
            end
            2: begin // serve, then change arrives during ACK
                @(negedge clk); vb.serve = 1'b1; vb.change = 1'b0;
                @(negedge clk); vb.serve = 1'b0; vb.change = 1'b1;
                check("late_ack1", w_obs, mk(0,0,0,0,1,1,1,0,0,tgt));
                @(negedge clk); vb.change = 1'b0;
                check("late_ack2", w_obs, mk(0,0,0,0,1,1,1,1,0,tgt));
                @(negedge clk);
                check("late_idle", w_obs, mk(0,0,0,0,0,0,1,1,0,tgt));
            end
            default: begin // change alone
                @(negedge clk); vb.serve = 1'b0; vb.change = 1'b1;
                @(negedge clk); vb.change = 1'b0;
                check("chg_ack", w_obs, mk(0,0,0,0,1,1,0,1,0,tgt));
                @(negedge clk);
                check("chg_idle", w_obs, mk(0,0,0,0,0,0,0,1,0,tgt));
            end
        endcase
    endtask

    initial begin
        vecs[0] = '{tgt: 4'd11, n: 3, codes: 8'b00_01_11_11, noise: 1'b0};
        vecs[1] = '{tgt: 4'd4,  n: 2, codes: 8'b00_00_10_10, noise: 1'b0};
        vecs[2] = '{tgt: 4'd0,  n: 0, codes: 8'b00_00_00_00, noise: 1'b0};
        vecs[3] = '{tgt: 4'd15, n: 3, codes: 8'b00_11_11_11, noise: 1'b0};
        vecs[4] = '{tgt: 4'd14, n: 4, codes: 8'b10_10_11_11, noise: 1'b0};
        vecs[5] = '{tgt: 4'd1,  n: 1, codes: 8'b00_00_00_01, noise: 1'b0};
        vecs[6] = '{tgt: 4'd3,  n: 2, codes: 8'b00_00_01_10, noise: 1'b0};
        vecs[7] = '{tgt: 4'd7,  n: 2, codes: 8'b00_00_10_11, noise: 1'b1};
        vecs[8] = '{tgt: 4'd4,  n: 2, codes: 8'b00_00_10_10, noise: 1'b1};

        vb.start  = 1'b0;
        vb.target = 4'd0;
        vb.serve  = 1'b0;
        vb.change = 1'b0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", w_obs, 13'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_purchase(vecs[i].tgt, vecs[i].n, vecs[i].codes, vecs[i].noise);
            respond(i % 4, vecs[i].tgt);
        end

        // No response from the machine.
        run_purchase(4'd2, 1, 8'b00_00_00_10, 1'b0);
`ifdef VEND_BUYER_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_wait", w_obs, mk(0,0,0,0,0,1,0,0,0,4'd2));
        end
        @(negedge clk);
        check("to_fired", w_obs, mk(0,0,0,0,0,0,0,0,1,4'd2));
        @(negedge clk);
        check("to_idle", w_obs, mk(0,0,0,0,0,0,0,0,1,4'd2));
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("wait_forever", w_obs, mk(0,0,0,0,0,1,0,0,0,4'd2));
        end
        respond(3, 4'd2);
`endif

        // Reset in the middle of a target=11 purchase.
        @(negedge clk); vb.start = 1'b1; vb.target = 4'd11;
        @(negedge clk); vb.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset", w_obs, mk(0,0,1,0,0,1,0,0,0,4'd10));
        rst = 1'b0;
        #1;
        check("reset_async", w_obs, 13'd0);
        @(negedge clk);
        check("reset_hold", w_obs, 13'd0);
        rst       = 1'b1;
        vb.start  = 1'b1;
        vb.target = 4'd2;
        @(negedge clk); vb.start = 1'b0;
        check("post_rst_dime", w_obs, mk(0,1,0,0,0,1,0,0,0,4'd2));
        @(negedge clk);
        check("post_rst_gap", w_obs, mk(0,0,0,0,0,1,0,0,0,4'd2));
        @(negedge clk);
        check("post_rst_vend", w_obs, mk(0,0,0,1,0,1,0,0,0,4'd2));
        @(negedge clk);
        check("post_rst_wait", w_obs, mk(0,0,0,0,0,1,0,0,0,4'd2));
        respond(0, 4'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
